fading_conv: RTL and testbench
==============================

# fading_conv

Time-varying complex FIR that applies the per-sample fading channel to a baseband sample stream. Sits directly downstream of `linterp`. It takes the 32 interpolated complex tap coefficients from `linterp` and convolves them with the complex input samples. It uses one complex multiply-accumulate per clock and produces one 18-bit complex output per accepted input sample.

## Interface
Parameters:
- `NTAPS`, 32: number of taps and delay-line depth; power of two.
- `DW`, 16: input sample width, signed Q1.15.
- `CW`, 16: coefficient width, signed Q1.15.
- `OW`, 18: output width, signed Q3.15.

Ports:
- `clk`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-high.
- `dv_in`  in  1  input sample valid.
- `ready`  out  1  block can accept a sample this cycle.
- `din_real`, `din_imag`  in  DW each  input sample.
- `coef_load`  in  1  one-cycle pulse that snapshots the coefficient bus.
- `coef_real`, `coef_imag`  in  [NTAPS-1:0][CW-1:0] each  tap coefficients from `linterp`.
- `dv_out`  out  1  one-cycle output valid.
- `dout_real`, `dout_imag`  out  OW each  convolution result.
- `overrun`  out  1  sticky flag: a sample arrived while `ready` was 0.

## Operation
- Reset values: `ready`=1, `dv_out`=0, `dout_*`=0, `overrun`=0. Reset also clears:
  - the delay line (all zeros) and write pointer (0);
  - the shadow and active coefficient banks (all zeros).
- States:
  - IDLE → MAC on `dv_in & ready`.
  - MAC lasts NTAPS cycles, tap index k = 0..NTAPS-1, then goes to DRAIN.
  - DRAIN lasts 3 cycles (pipeline flush), then goes to OUT.
  - OUT lasts 1 cycle with `dv_out`=1, then returns to IDLE.
  - `ready` = (state == IDLE).
- Sample acceptance:
  - The sample is written at the write pointer.
  - The pointer advances modulo NTAPS after the write, wrapping 31→0.
  - Tap k uses x[n-k], read at (wptr_at_accept − k) mod NTAPS.
- Coefficient snapshot and use:
  - `coef_load` copies the bus into the shadow bank.
  - The shadow bank is copied into the active bank at acceptance.
  - If `coef_load` and acceptance coincide, the new bus values are used for this sample.
  - `coef_load` during MAC/DRAIN/OUT never disturbs the sample in progress.
- Complex product per tap:
  - re = xr·cr − xi·ci; im = xr·ci + xi·cr.
  - Full precision: 32-bit partial products, 33-bit sum.
  - Accumulator is 38 bits signed (33 + log2 NTAPS), cleared at start of MAC.
- Output scaling:
  - Add 2^14, arithmetic shift right 15 (round half up).
  - Saturate to OW bits: [−131072, 131071].
- `dv_in` while `ready`=0: the sample is dropped, `overrun` is set, and the sample in progress is unaffected. Only reset clears `overrun`.
- Reset mid-operation:
  - Aborts immediately; no `dv_out` for the aborted sample.
  - State returns to IDLE and history is zeroed.

## Timing
- Accept at cycle 0 (edge where `dv_in & ready`).
- `ready` drops at cycle 1.
- MAC occupies cycles 1..32 and DRAIN cycles 33..35.
- `dv_out`=1 with valid `dout_*` at cycle 36. `dout_*` holds its value until the next `dv_out`.
- `ready`=1 at cycle 37, so minimum input spacing is 37 cycles.
- MAC pipeline: address/operand register → product register → sum/accumulate register. Fixed, no backpressure on outputs.

## Structure
- `fading_conv_pkg` holds:
  - NTAPS, DW, CW, OW and ACCW=38 constants;
  - the state enum (IDLE, MAC, DRAIN, OUT);
  - a `cplx_t` struct {real, imag} typedef.
- Sub-module `cplx_mac`: 3-stage complex multiply-accumulate with a `clear` input, taking operands and producing a 38-bit complex accumulator. Rounding and saturation stay in the top.
- The delay line is a register array (needed for single-cycle reset clear).

## Test plan
- Impulse gain: coef[0]=(0x4000,0), others 0; load; input (0x7FFF,0) → `dout`=(16384,0) exactly 36 cycles after accept.
- Delay/wrap:
  - Setup: coef[3]=(0x7FFF,0) only; inputs (0x4000,0),0,0,0.
  - Outputs 1–3 are 0; output 4 is (16384,0) (16383.5 rounds up).
  - Repeat for 40 samples to cross pointer wrap.
- Complex rotation: coef[0]=(0,0x4000); input (0x4000,0) → (0,8192). Input (0,0x4000) → (−8192,0).
- Saturation:
  - All coefs (0x7FFF,0); input (0x7FFF,0) for 32 samples → 32nd output (131071,0).
  - Same with input (−0x8000,0) → (−131072,0).
- Overrun: assert `dv_in` at cycle 5 after accept → `overrun`=1, output unchanged, next sample accepted normally at cycle 37+.
- Reset/coef timing:
  - `reset` at cycle 10 → no `dv_out`, `ready`=1 next cycle, next output reflects zeroed history.
  - `coef_load` with new values during MAC → current output uses old coefs, next sample uses new.

Source files
------------

// File: rtl/fading_conv_pkg.sv
// rtl/fading_conv_pkg.sv - shared constants, types and output scaling for fading_conv
//
// Purpose: widths of the fading-channel FIR, FSM state encoding, the complex
// sample type and the round/saturate helper used on the accumulator.
// Ports: none (package).

package fading_conv_pkg;

   localparam int NTAPS = 32;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int OW    = 18;
   localparam int ACCW  = 38;

   // Width of the accumulator after dropping the 15 fractional bits
   localparam int SW = ACCW - 15;
   localparam logic signed [SW-1:0] SAT_HI = SW'(2**(OW-1) - 1);
   localparam logic signed [SW-1:0] SAT_LO = SW'(-(2**(OW-1)));

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   // "real" is a reserved word, hence re/im
   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   // Q.30 accumulator -> Q3.15: add half an LSB, shift, clamp
   function automatic logic signed [OW-1:0] round_sat(input logic signed [ACCW-1:0] a);
      logic signed [SW-1:0] s;
      s = SW'((a + ACCW'(16384)) >>> 15);
      if (s > SAT_HI)
         round_sat = SAT_HI[OW-1:0];
      else if (s < SAT_LO)
         round_sat = SAT_LO[OW-1:0];
      else
         round_sat = s[OW-1:0];
   endfunction

endpackage

// File: rtl/cplx_mac.sv
// rtl/cplx_mac.sv - three-stage complex multiply-accumulate
//
// Purpose: operand register -> four partial products -> complex sum and
// accumulate, full precision throughout.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             zeroes the accumulator and flushes the pipeline
//   en                operands x, c are valid this cycle
//   x, c              complex sample and coefficient
//   acc_re, acc_im    running complex accumulator (ACCW bits)

module cplx_mac
   import fading_conv_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   en,
   input  cplx_t                  x,
   input  cplx_t                  c,
   output logic signed [ACCW-1:0] acc_re,
   output logic signed [ACCW-1:0] acc_im
);

   localparam int PW = 2 * DW;
   localparam int SUMW = PW + 1;

   cplx_t                 x_q, c_q;
   logic                  v1, v2;
   logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
   logic signed [SUMW-1:0] s_re, s_im;

   always_comb begin
      s_re = SUMW'(p_rr) - SUMW'(p_ii);
      s_im = SUMW'(p_ri) + SUMW'(p_ir);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         x_q    <= '0;
         c_q    <= '0;
         p_rr   <= '0;
         p_ii   <= '0;
         p_ri   <= '0;
         p_ir   <= '0;
         acc_re <= '0;
         acc_im <= '0;
      end else begin
         v1   <= en;
         x_q  <= x;
         c_q  <= c;
         v2   <= v1;
         p_rr <= PW'($signed(x_q.re)) * PW'($signed(c_q.re));
         p_ii <= PW'($signed(x_q.im)) * PW'($signed(c_q.im));
         p_ri <= PW'($signed(x_q.re)) * PW'($signed(c_q.im));
         p_ir <= PW'($signed(x_q.im)) * PW'($signed(c_q.re));
         if (v2) begin
            acc_re <= acc_re + ACCW'(s_re);
            acc_im <= acc_im + ACCW'(s_im);
         end
      end
   end

endmodule

// File: rtl/fading_conv.sv
// rtl/fading_conv.sv - time-varying complex FIR applying the fading channel
//
// Purpose: convolves each accepted complex sample with NTAPS complex taps,
// one complex MAC per clock, one rounded/saturated output per sample.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   dv_in, din_real/imag     input sample and valid
//   ready                    high in IDLE only
//   coef_load                snapshot coef_real/imag into the shadow bank
//   coef_real, coef_imag     tap coefficient buses
//   dv_out, dout_real/imag   one-cycle result strobe; data holds until next
//   overrun                  sticky: sample offered while busy

module fading_conv
   import fading_conv_pkg::*;
#(
   parameter int NTAPS = fading_conv_pkg::NTAPS,
   parameter int DW    = fading_conv_pkg::DW,
   parameter int CW    = fading_conv_pkg::CW,
   parameter int OW    = fading_conv_pkg::OW
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       dv_in,
   output logic                       ready,
   input  logic signed [DW-1:0]       din_real,
   input  logic signed [DW-1:0]       din_imag,
   input  logic                       coef_load,
   input  logic [NTAPS-1:0][CW-1:0]   coef_real,
   input  logic [NTAPS-1:0][CW-1:0]   coef_imag,
   output logic                       dv_out,
   output logic signed [OW-1:0]       dout_real,
   output logic signed [OW-1:0]       dout_imag,
   output logic                       overrun
);

   localparam int AW = $clog2(NTAPS);

   state_t                state, state_nxt;
   logic [AW-1:0]         wptr, base, k;
   logic [1:0]            dcnt;
   logic                  accept;
   cplx_t                 dline  [NTAPS];
   cplx_t                 shadow [NTAPS];
   cplx_t                 active [NTAPS];
   cplx_t                 x_op, c_op;
   logic signed [ACCW-1:0] acc_re, acc_im;

   assign ready  = (state == IDLE);
   assign dv_out = (state == OUT);
   assign accept = dv_in & ready;

   // base holds the slot of x[n]; AW-bit subtraction gives the modulo wrap
   assign x_op = dline[base - k];
   assign c_op = active[k];

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MAC;
         MAC:     if (k == AW'(NTAPS - 1)) state_nxt = DRAIN;
         DRAIN:   if (dcnt == 2'd2) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k    <= '0;
         dcnt <= 2'd0;
      end else begin
         k    <= (state == MAC)   ? k + 1'b1    : '0;
         dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr      <= '0;
         base      <= '0;
         overrun   <= 1'b0;
         dout_real <= '0;
         dout_imag <= '0;
         for (int i = 0; i < NTAPS; i++) begin
            dline[i]  <= '0;
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (dv_in && !ready)
            overrun <= 1'b1;
         if (coef_load)
            for (int i = 0; i < NTAPS; i++)
               shadow[i] <= {coef_real[i], coef_imag[i]};
         if (accept) begin
            dline[wptr] <= {din_real, din_imag};
            base        <= wptr;
            wptr        <= wptr + 1'b1;
            // a load coinciding with acceptance wins over the stale shadow
            for (int i = 0; i < NTAPS; i++)
               active[i] <= coef_load ? {coef_real[i], coef_imag[i]} : shadow[i];
         end
         // accumulator settles in the last DRAIN cycle
         if (state == DRAIN && dcnt == 2'd2) begin
            dout_real <= round_sat(acc_re);
            dout_imag <= round_sat(acc_im);
         end
      end
   end

   cplx_mac u_mac (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .en     (state == MAC),
      .x      (x_op),
      .c      (c_op),
      .acc_re (acc_re),
      .acc_im (acc_im)
   );

endmodule

// File: tb/tb_fading_conv.sv
// tb/tb_fading_conv.sv - directed self-checking bench for fading_conv

module tb_fading_conv;

   localparam int NT = 32;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   dv_in;
   logic                   ready;
   logic signed [15:0]     din_real, din_imag;
   logic                   coef_load;
   logic [NT-1:0][15:0]    coef_real, coef_imag;
   logic                   dv_out;
   logic signed [17:0]     dout_real, dout_imag;
   logic                   overrun;

   int total = 0;
   int bad   = 0;

   logic signed [17:0] gr, gi;
   int                 lat;

   always #5 clk = ~clk;

   fading_conv dut (
      .clk       (clk),
      .reset     (reset),
      .dv_in     (dv_in),
      .ready     (ready),
      .din_real  (din_real),
      .din_imag  (din_imag),
      .coef_load (coef_load),
      .coef_real (coef_real),
      .coef_imag (coef_imag),
      .dv_out    (dv_out),
      .dout_real (dout_real),
      .dout_imag (dout_imag),
      .overrun   (overrun)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_bus();
      coef_real = '0;
      coef_imag = '0;
   endtask

   task automatic load_coefs();
      coef_load = 1'b1;
      @(negedge clk);
      coef_load = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Offers one sample and follows it to dv_out. ovr_c/rst_c/ld_c: cycle
   // (counted from accept) at which to inject a busy sample, a reset or a
   // coef_load; ld_c == 0 loads together with the accept. lat = -1 if no output.
   task automatic run_sample(input logic signed [15:0] re, input logic signed [15:0] im,
                             input int ovr_c, input int rst_c, input int ld_c,
                             output logic signed [17:0] o_re, output logic signed [17:0] o_im,
                             output int o_lat);
      int w;
      int c;
      w = 0;
      o_re = '0;
      o_im = '0;
      o_lat = -1;
      while (!ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!ready) begin
         chk("ready_wait", ready, 1);
         return;
      end
      dv_in     = 1'b1;
      din_real  = re;
      din_imag  = im;
      coef_load = (ld_c == 0);
      @(negedge clk);
      dv_in     = 1'b0;
      coef_load = 1'b0;
      din_real  = '0;
      din_imag  = '0;
      chk("ready_low", ready, 0);
      c = 1;
      while (o_lat < 0 && c < 60) begin
         if (rst_c > 0 && c == rst_c + 1)
            chk("rst_ready", ready, 1);
         if (dv_out) begin
            o_lat = c;
            o_re  = dout_real;
            o_im  = dout_imag;
         end else begin
            if (c == ovr_c) begin
               dv_in    = 1'b1;
               din_real = 16'sh1234;
               din_imag = 16'sh0567;
            end
            reset     = (c == rst_c);
            coef_load = (c == ld_c);
            @(negedge clk);
            dv_in     = 1'b0;
            reset     = 1'b0;
            coef_load = 1'b0;
            din_real  = '0;
            din_imag  = '0;
            c++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      dv_in     = 1'b0;
      coef_load = 1'b0;
      din_real  = '0;
      din_imag  = '0;
      clear_bus();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready",   ready, 1);
      chk("rst_dv_out",  dv_out, 0);
      chk("rst_dout_re", dout_real, 0);
      chk("rst_dout_im", dout_imag, 0);
      chk("rst_overrun", overrun, 0);

      // impulse gain and latency
      clear_bus();
      coef_real[0] = 16'h4000;
      load_coefs();
      run_sample(16'sh7FFF, 16'sh0000, -1, -1, -1, gr, gi, lat);
      chk("imp_lat", lat, 36);
      chk("imp_re", gr, 16384);
      chk("imp_im", gi, 0);
      @(negedge clk);
      chk("imp_ready_back", ready, 1);
      chk("imp_dv_drop", dv_out, 0);
      chk("imp_hold", dout_real, 16384);

      // delay through tap 3, across pointer wrap
      do_reset();
      clear_bus();
      coef_real[3] = 16'h7FFF;
      load_coefs();
      for (int i = 0; i < 40; i++) begin
         run_sample((i % 4 == 0) ? 16'sh4000 : 16'sh0000, 16'sh0000, -1, -1, -1, gr, gi, lat);
         chk($sformatf("wrap%0d_re", i), gr, (i % 4 == 3) ? 16384 : 0);
         chk($sformatf("wrap%0d_im", i), gi, 0);
      end

      // complex rotation by j/2
      do_reset();
      clear_bus();
      coef_imag[0] = 16'h4000;
      load_coefs();
      run_sample(16'sh4000, 16'sh0000, -1, -1, -1, gr, gi, lat);
      chk("rot1_re", gr, 0);
      chk("rot1_im", gi, 8192);
      run_sample(16'sh0000, 16'sh4000, -1, -1, -1, gr, gi, lat);
      chk("rot2_re", gr, -8192);
      chk("rot2_im", gi, 0);

      // load coinciding with accept uses the new bus
      clear_bus();
      coef_real[0] = 16'h7FFF;
      run_sample(16'sh4000, 16'sh0000, -1, -1, 0, gr, gi, lat);
      chk("ldacc_re", gr, 16384);
      chk("ldacc_im", gi, 0);

      // load during MAC leaves the sample in progress alone
      clear_bus();
      coef_real[0] = 16'h2000;
      run_sample(16'sh4000, 16'sh0000, -1, -1, 10, gr, gi, lat);
      chk("ldmac_cur_re", gr, 16384);
      run_sample(16'sh4000, 16'sh0000, -1, -1, -1, gr, gi, lat);
      chk("ldmac_next_re", gr, 4096);
      chk("ldmac_next_im", gi, 0);

      // overrun
      do_reset();
      chk("ovr_clear", overrun, 0);
      clear_bus();
      coef_real[0] = 16'h4000;
      coef_real[1] = 16'h4000;
      load_coefs();
      run_sample(16'sh7FFF, 16'sh0000, 5, -1, -1, gr, gi, lat);
      chk("ovr_lat", lat, 36);
      chk("ovr_re", gr, 16384);
      chk("ovr_im", gi, 0);
      chk("ovr_flag", overrun, 1);
      run_sample(16'sh2000, 16'sh0000, -1, -1, -1, gr, gi, lat);
      chk("ovr_next_lat", lat, 36);
      chk("ovr_next_re", gr, 20480);
      chk("ovr_sticky", overrun, 1);

      // reset mid-MAC
      run_sample(16'sh7FFF, 16'sh0000, -1, 10, -1, gr, gi, lat);
      chk("rstmid_no_out", lat, -1);
      chk("rstmid_ready", ready, 1);
      chk("rstmid_dout", dout_real, 0);
      chk("rstmid_overrun", overrun, 0);
      load_coefs();
      run_sample(16'sh2000, 16'sh0000, -1, -1, -1, gr, gi, lat);
      chk("rstmid_next_re", gr, 4096);
      chk("rstmid_next_im", gi, 0);

      // saturation, positive then negative
      do_reset();
      for (int i = 0; i < NT; i++) begin
         coef_real[i] = 16'h7FFF;
         coef_imag[i] = 16'h0000;
      end
      load_coefs();
      for (int i = 0; i < NT; i++) begin
         run_sample(16'sh7FFF, 16'sh0000, -1, -1, -1, gr, gi, lat);
         if (i == 3)
            chk("sat_pre4_re", gr, 131064);
      end
      chk("sat_pos_re", gr, 131071);
      chk("sat_pos_im", gi, 0);
      for (int i = 0; i < NT; i++)
         run_sample(16'sh8000, 16'sh0000, -1, -1, -1, gr, gi, lat);
      chk("sat_neg_re", gr, -131072);
      chk("sat_neg_im", gi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
